// File: rtl/fetch_pipe_if.sv
// Instruction/PC/valid bundle carried between fetch and decode.
// The producer drives it through the master modport; the consumer reads it through slave.
interface fetch_pipe_if #(
  parameter int INSTR_W = 32,
  parameter int PC_W    = 64
);
  logic [INSTR_W-1:0] instr;
  logic [PC_W-1:0]    pc;
  logic               valid;

  modport master (output instr, output pc, output valid);
  modport slave  (input  instr, input  pc, input  valid);
endinterface

// File: rtl/fetch_pipe.sv
// Fetch-to-decode register chain of DEPTH stages with stall, flush-to-NOP and
// saturating debug counters. Outputs come straight from the oldest stage.
module fetch_pipe #(
  parameter int          INSTR_W  = 32,
  parameter int          PC_W     = 64,
  parameter int          DEPTH    = 1,
  parameter logic [31:0] NOP_WORD = 32'hD503201F,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  fetch_pipe_if.slave      src,
  fetch_pipe_if.master     dst,
  input  logic             stall,
  input  logic             flush,
  output logic             fetch_hold,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
    $error("fetch_pipe: DEPTH must be in 1..4");
  end

  localparam logic [INSTR_W-1:0] NOP = INSTR_W'(NOP_WORD);

  typedef struct packed {
    logic               valid;
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } stage_t;

  localparam stage_t BUBBLE = '{valid: 1'b0, instr: NOP, pc: '0};

  stage_t pipe [DEPTH];
  stage_t head;

  // Invalid fetches enter as canonical bubbles so decode never sees stale fields.
  always_comb begin
    head = BUBBLE;
    if (src.valid) begin
      head.valid = 1'b1;
      head.instr = src.instr;
      head.pc    = src.pc;
    end
  end

  // NOTE: every stage is reset (this is a short flop chain, not a RAM) because the
  // invalid => NOP/pc 0 invariant must hold on the very first cycle out of reset.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      for (int k = 0; k < DEPTH; k++) pipe[k] <= BUBBLE;
    end else if (!stall) begin
      pipe[0] <= head;
      for (int k = 1; k < DEPTH; k++) pipe[k] <= pipe[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else if (flush) begin
      if (flush_count != '1) flush_count <= flush_count + CNT_W'(1);
    end else if (stall) begin
      if (stall_count != '1) stall_count <= stall_count + CNT_W'(1);
    end
  end

  // NOTE: reset is folded in so the PC unit is never told to hold while the
  // pipeline is being cleared, even if the hazard unit drives stall during reset.
  assign fetch_hold = stall & ~flush & ~reset;

  assign dst.valid = pipe[DEPTH-1].valid;
  assign dst.instr = pipe[DEPTH-1].instr;
  assign dst.pc    = pipe[DEPTH-1].pc;

endmodule

// File: tb/tb_fetch_pipe.sv
// Directed bench: four fetch_pipe instances (DEPTH 1..4) share one input stream and
// control, and each scenario checks the instance whose depth it targets.
module tb_fetch_pipe;

  localparam logic [31:0] NOP = 32'hD503201F;

  logic clk = 1'b0;
  logic reset, stall, flush;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  fetch_pipe_if #(.INSTR_W(32), .PC_W(64)) in_if ();
  fetch_pipe_if #(.INSTR_W(32), .PC_W(64)) o1 ();
  fetch_pipe_if #(.INSTR_W(32), .PC_W(64)) o2 ();
  fetch_pipe_if #(.INSTR_W(32), .PC_W(64)) o3 ();
  fetch_pipe_if #(.INSTR_W(32), .PC_W(64)) o4 ();

  logic        hold1, hold2, hold3, hold4;
  logic [15:0] sc1, fc1, sc2, fc2, sc3, fc3;
  logic [3:0]  sc4, fc4;

  fetch_pipe #(.DEPTH(1)) d1 (.clk(clk), .reset(reset), .src(in_if), .dst(o1),
    .stall(stall), .flush(flush), .fetch_hold(hold1), .stall_count(sc1), .flush_count(fc1));
  fetch_pipe #(.DEPTH(2)) d2 (.clk(clk), .reset(reset), .src(in_if), .dst(o2),
    .stall(stall), .flush(flush), .fetch_hold(hold2), .stall_count(sc2), .flush_count(fc2));
  fetch_pipe #(.DEPTH(3)) d3 (.clk(clk), .reset(reset), .src(in_if), .dst(o3),
    .stall(stall), .flush(flush), .fetch_hold(hold3), .stall_count(sc3), .flush_count(fc3));
  fetch_pipe #(.DEPTH(4), .CNT_W(4)) d4 (.clk(clk), .reset(reset), .src(in_if), .dst(o4),
    .stall(stall), .flush(flush), .fetch_hold(hold4), .stall_count(sc4), .flush_count(fc4));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic v, input logic [31:0] instr, input logic [63:0] pc);
    in_if.valid = v;
    in_if.instr = instr;
    in_if.pc    = pc;
  endtask

  function automatic logic [31:0] word(input logic [63:0] pc);
    return 32'hA000_0000 | pc[31:0];
  endfunction

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    feed(1'b0, 32'h0, 64'h0);

    // Reset for two cycles; stall asserted during reset must not raise fetch_hold.
    tick();
    check("rst_valid", o2.valid, 0);
    check("rst_instr", o2.instr, NOP);
    stall = 1'b1;
    #1;
    check("rst_hold", hold2, 0);
    tick();
    stall = 1'b0;
    check("rst_pc", o2.pc, 0);
    check("rst_sc", sc2, 0);

    // Pass-through on DEPTH=2 (and DEPTH=1 equivalence).
    reset = 1'b0;
    feed(1'b1, 32'h91000421, 64'd0);
    tick();
    check("pt_first_valid", o2.valid, 0);
    check("pt_first_instr", o2.instr, NOP);
    check("d1_instr", o1.instr, 32'h91000421);
    check("d1_valid", o1.valid, 1);
    feed(1'b1, 32'h8B020020, 64'd4);
    tick();
    check("pt_w0_instr", o2.instr, 32'h91000421);
    check("pt_w0_pc", o2.pc, 0);
    check("pt_w0_valid", o2.valid, 1);
    feed(1'b1, 32'hF84003E1, 64'd8);
    tick();
    check("pt_w1_instr", o2.instr, 32'h8B020020);
    check("pt_w1_pc", o2.pc, 4);
    feed(1'b0, 32'h0, 64'h0);
    tick();
    check("pt_w2_instr", o2.instr, 32'hF84003E1);
    check("pt_w2_pc", o2.pc, 8);

    // Stall hold: stall 3 cycles while pc 4 is on the DEPTH=2 output.
    feed(1'b1, word(0), 64'd0);  tick();
    feed(1'b1, word(4), 64'd4);  tick();
    check("st_pre_pc", o2.pc, 0);
    feed(1'b1, word(8), 64'd8);  tick();
    check("st_on_pc", o2.pc, 4);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      feed(1'b1, word(64'd100 + 64'(i)), 64'd100 + 64'(i));
      #1;
      check("st_hold_on", hold2, 1);
      tick();
      check("st_held_pc", o2.pc, 4);
      check("st_held_instr", o2.instr, word(4));
    end
    stall = 1'b0;
    feed(1'b1, word(12), 64'd12);
    #1;
    check("st_hold_off", hold2, 0);
    tick();
    check("st_after_pc8", o2.pc, 8);
    feed(1'b0, 32'h0, 64'h0);
    tick();
    check("st_after_pc12", o2.pc, 12);
    check("st_count", sc2, 3);

    // Flush beats stall on a full DEPTH=3 pipeline.
    feed(1'b1, word(32), 64'd32); tick();
    feed(1'b1, word(36), 64'd36); tick();
    feed(1'b1, word(40), 64'd40); tick();
    check("fl_full_pc", o3.pc, 32);
    check("fl_full_valid", o3.valid, 1);
    stall = 1'b1; flush = 1'b1;
    feed(1'b1, word(64), 64'd64);
    #1;
    check("fl_hold", hold3, 0);
    tick();
    stall = 1'b0; flush = 1'b0;
    check("fl_valid", o3.valid, 0);
    check("fl_instr", o3.instr, NOP);
    check("fl_pc", o3.pc, 0);
    check("fl_fcount", fc3, 1);
    check("fl_scount", sc3, 3);
    feed(1'b0, 32'h0, 64'h0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("fl_drain_valid", o3.valid, 0);
      check("fl_drain_instr", o3.instr, NOP);
    end

    // Bubble on DEPTH=1 from in_valid=0 with garbage fields.
    feed(1'b0, 32'hFFFFFFFF, 64'h123);
    tick();
    check("bub_valid", o1.valid, 0);
    check("bub_instr", o1.instr, NOP);
    check("bub_pc", o1.pc, 0);

    // Saturation: d4 has CNT_W=4 and starts at 3 stall cycles.
    stall = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 11) check("sat_14", sc4, 14);
      if (i == 12) check("sat_15", sc4, 15);
    end
    stall = 1'b0;
    check("sat_hold", sc4, 15);
    check("nosat_16b", sc2, 23);

    // Reset mid-operation on a full DEPTH=4 pipeline with stall and flush asserted.
    for (int i = 0; i < 4; i++) begin
      feed(1'b1, word(64'h100 + 64'(4 * i)), 64'h100 + 64'(4 * i));
      tick();
    end
    check("mr_full_pc", o4.pc, 64'h100);
    check("mr_full_valid", o4.valid, 1);
    reset = 1'b1; stall = 1'b1; flush = 1'b1;
    tick();
    check("mr_valid", o4.valid, 0);
    check("mr_instr", o4.instr, NOP);
    check("mr_pc", o4.pc, 0);
    check("mr_scount", sc4, 0);
    check("mr_fcount", fc4, 0);
    check("mr_hold", hold4, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
